// File: rtl/ram_wr_arbiter_if.sv
// rtl/ram_wr_arbiter_if.sv - request, clear and RAM write-port bundle for ram_wr_arbiter
// Ports (signals):
//   req_valid/req_addr/req_data/req_ready : packed per-requester write handshake
//   clr_start/clr_busy/clr_done           : hardware zero-fill control and status
//   ram_we/ram_waddr/ram_wdata            : registered RAM write port
// Modports: master = requesters/RAM side, slave = arbiter.
interface ram_wr_arbiter_if #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 32,
  parameter int N_REQ = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*AW-1:0]    req_addr;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   clr_start;
  logic                   clr_busy;
  logic                   clr_done;
  logic                   ram_we;
  logic [AW-1:0]          ram_waddr;
  logic [WIDTH-1:0]       ram_wdata;

  modport master (
    output req_valid, req_addr, req_data, clr_start,
    input  req_ready, clr_busy, clr_done, ram_we, ram_waddr, ram_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_data, clr_start,
    output req_ready, clr_busy, clr_done, ram_we, ram_waddr, ram_wdata
  );
endinterface

// File: rtl/ram_wr_arbiter.sv
// rtl/ram_wr_arbiter.sv - round-robin write-port arbiter with zero-fill clear sequencer
// Ports:
//   clk : clock, all state on posedge
//   rst : asynchronous active-low reset
//   bus : ram_wr_arbiter_if.slave (requests in, one-hot combinational req_ready out,
//         clr_start in, registered clr_busy/clr_done, registered ram_we/ram_waddr/ram_wdata)
// Optional build macro: RAM_WR_ARB_CLR_ON_RESET_EN (reset into CLEAR, auto zero-fill after release).
module ram_wr_arbiter #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 32,
  parameter int N_REQ = 4
) (
  input logic            clk,
  input logic            rst,
  ram_wr_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

`ifdef RAM_WR_ARB_CLR_ON_RESET_EN
  localparam logic [0:0] RST_STATE = CLEAR;
  localparam logic       RST_BUSY  = 1'b1;
`else
  localparam logic [0:0] RST_STATE = IDLE;
  localparam logic       RST_BUSY  = 1'b0;
`endif

  logic [0:0]       state;
  logic [PW-1:0]    rr_ptr;
  logic [AW-1:0]    clr_cnt;
  logic             we_q;
  logic [AW-1:0]    waddr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             busy_q;
  logic             done_q;

  logic [AW-1:0]    addr_arr [N_REQ];
  logic [WIDTH-1:0] data_arr [N_REQ];

  logic [N_REQ-1:0] grant;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    scan_idx;
  logic             grant_any;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i] = bus.req_addr[i*AW +: AW];
    assign data_arr[i] = bus.req_data[i*WIDTH +: WIDTH];
  end

  // Rotating priority search starting just after the last winner. Gating on
  // rst keeps req_ready low during reset; clr_start pre-empts any grant.
  always_comb begin
    grant     = '0;
    grant_idx = rr_ptr;
    scan_idx  = '0;
    grant_any = 1'b0;
    if (rst && (state == IDLE) && !bus.clr_start) begin
      for (int k = 1; k <= N_REQ; k++) begin
        scan_idx = PW'((int'(rr_ptr) + k) % N_REQ);
        if (!grant_any && bus.req_valid[scan_idx]) begin
          grant_any       = 1'b1;
          grant_idx       = scan_idx;
          grant[scan_idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RST_STATE;
      rr_ptr  <= PW'(N_REQ - 1);
      clr_cnt <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= RST_BUSY;
      done_q  <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (state == CLEAR) begin
        // clr_start is deliberately ignored here: no restart, no queuing.
        we_q    <= 1'b1;
        waddr_q <= clr_cnt;
        wdata_q <= '0;
        clr_cnt <= clr_cnt + 1'b1;  // wraps back to 0 after DEPTH-1
        if (clr_cnt == AW'(DEPTH - 1)) begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end else if (bus.clr_start) begin
        state  <= CLEAR;
        busy_q <= 1'b1;
      end else if (grant_any) begin
        rr_ptr  <= grant_idx;
        we_q    <= 1'b1;
        waddr_q <= addr_arr[grant_idx];
        wdata_q <= data_arr[grant_idx];
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.clr_busy  = busy_q;
  assign bus.clr_done  = done_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_waddr = waddr_q;
  assign bus.ram_wdata = wdata_q;

endmodule

// File: doc/ram_wr_arbiter.md
Name: ram_wr_arbiter

Overview:
- Sequences the single write port of the 2R1W async-read register RAM.
- Shares the write port between N_REQ requesters with round-robin valid/ready arbitration.
- Provides a hardware clear sequencer that zero-fills every RAM entry, one address per cycle.
- Sits directly in front of the RAM write port; the RAM read ports are untouched.

Parameters:
- DEPTH, 128, RAM entries. Must be a power of 2 and ≥2. AW = $clog2(DEPTH) is a derived localparam.
- WIDTH, 32, data width in bits. Matches the RAM data width.
- N_REQ, 4, number of write requesters, 2..8.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  N_REQ  per-requester write request.
- req_addr  in  N_REQ*AW  packed addresses; requester i occupies [i*AW +: AW].
- req_data  in  N_REQ*WIDTH  packed data; requester i occupies [i*WIDTH +: WIDTH].
- req_ready  out  N_REQ  one-hot grant, combinational; transfer when req_valid[i]&req_ready[i].
- clr_start  in  1  request a full-RAM zero-fill.
- clr_busy  out  1  registered; high while in CLEAR state.
- clr_done  out  1  registered; 1-cycle pulse with the final clear write.
- ram_we  out  1  registered RAM write enable.
- ram_waddr  out  AW  registered RAM write address.
- ram_wdata  out  WIDTH  registered RAM write data.

Behaviour:
- Reset values (rst=0): state=IDLE, rr_ptr=N_REQ-1, clr_cnt=0, ram_we=0, ram_waddr=0, ram_wdata=0, clr_busy=0, clr_done=0. req_ready=0 while rst=0.
- Write stage: ram_we/ram_waddr/ram_wdata form one output register, loaded each cycle.
  - Accepted transfer or clear step in cycle t -> RAM write presented in cycle t+1. Latency is exactly 1.
  - Otherwise ram_we=0 and addr/data hold their previous values.
- Arbitration in IDLE with clr_start=0:
  - Search req_valid starting at index (rr_ptr+1) mod N_REQ, wrapping.
  - The first set bit gets req_ready; at most one grant per cycle.
  - On grant i, rr_ptr<=i. With no valid request, rr_ptr holds.
  - req_ready is never asserted for a requester whose req_valid=0.
- Requesters must hold valid/addr/data stable until accepted. The arbiter does not buffer.
- State machine:
  - IDLE -> CLEAR when clr_start=1. req_ready=0 in that cycle: clear wins over requests.
  - CLEAR: each cycle load the write stage with we=1, addr=clr_cnt, data=0, then clr_cnt++. req_ready=0 throughout.
  - CLEAR -> IDLE after loading clr_cnt=DEPTH-1; clr_cnt returns to 0.
- Clear timing:
  - clr_start at cycle 0 -> clr_busy=1 in cycles 1..DEPTH.
  - ram_we addresses 0..DEPTH-1 in cycles 2..DEPTH+1.
  - clr_done=1 in cycle DEPTH+1 only.
  - Requests can be granted in cycle DEPTH+1; their writes land in DEPTH+2, after the clear completes.
- clr_start while in CLEAR is ignored; no restart and no queuing.
- Reset mid-clear aborts immediately to reset values. The RAM is left partially cleared.
- The address counter wraps naturally at AW bits; no out-of-range address is ever generated.

Optional Feature:
- Macro: RAM_WR_ARB_CLR_ON_RESET_EN.
- Defined:
  - Reset state is CLEAR, with clr_cnt=0 and clr_busy reset value 1.
  - After rst releases, a full clear runs automatically: writes to addr 0..DEPTH-1 in the first DEPTH cycles after release, clr_done pulses with the last write, then IDLE.
  - All requests are blocked until then.
- Undefined: reset state is IDLE as above, and clear occurs only on clr_start.

Test Plan:
- Reset, N_REQ=4, all req_valid=4'b1111 held -> grants in order 0,1,2,3,0; ram_waddr follows each grant 1 cycle later; exactly one req_ready bit per cycle.
- req_valid=4'b0100 alone, then 4'b0101 -> grant 2, then grant 0 (search wraps from 3 to 0); ram_we=0 in idle cycles.
- DEPTH=8, clr_start pulse at cycle 0 -> clr_busy cycles 1..8; ram_we addr 0..7 with data 0 in cycles 2..9; clr_done only in cycle 9.
- clr_start with req_valid=4'b0001 in the same cycle, clr_start re-pulsed mid-clear -> req_ready=0 until cycle 9; exactly 8 clear writes; req 0 write (addr 5, data 0xDEADBEEF) appears at cycle 10.
- rst asserted during CLEAR at clr_cnt=3 -> all outputs at reset values asynchronously; after release state is IDLE and requests are granted normally.
- RAM_WR_ARB_CLR_ON_RESET_EN defined, DEPTH=8 -> after rst release clr_busy=1, writes to addr 0..7, clr_done with the last write, then grants resume.
